multi_blinker: RTL and testbench

MULTI_BLINKER -- requirements
Module: multi_blinker

---
 rtl/multi_blinker_if.sv | 27 ++
 rtl/multi_blinker.sv | 190 +++++++++++++++++++
 tb/tb_multi_blinker.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_blinker_if.sv
// Configuration write channel for multi_blinker: valid/ready handshake carrying
// a channel index, a field select and the field data.
interface multi_blinker_if #(
  parameter int unsigned WIDTH = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [3:0]       cfg_chan;
  logic [1:0]       cfg_sel;
  logic [WIDTH-1:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_sel,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_sel,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/multi_blinker.sv
// Multi-channel LED blinker: shared tick prescaler, per-channel phase counter with
// period/duty/offset/mode fields. One-shot mode exists only with MULTI_BLINKER_ONESHOT_EN.
module multi_blinker #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 1000
) (
  input  logic                clk,
  input  logic                rst,
  multi_blinker_if.slave      cfg,
  output logic                tick,
  output logic [CHANNELS-1:0] blink_out,
  output logic [CHANNELS-1:0] busy
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] SEL_PERIOD = 2'd0;
  localparam logic [1:0] SEL_DUTY   = 2'd1;
  localparam logic [1:0] SEL_OFFSET = 2'd2;
  localparam logic [1:0] SEL_MODE   = 2'd3;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  // ---------------------------------------------------------------------------
  // Tick prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  // tick_q mirrors (presc_q == PRESC_MAX) but as a flop, so it is cleared by reset
  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    tick_d  = (presc_d == PRESC_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  // ---------------------------------------------------------------------------
  // Config handshake: ready drops for one cycle after every accepted write
  // ---------------------------------------------------------------------------
  logic ack_q;
  logic accept;

  assign cfg.cfg_ready = ~rst & ~ack_q;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= accept;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] offset_q, offset_d;
    logic [WIDTH-1:0] ph_q, ph_d;
    logic [1:0]       mode_q, mode_d;
    logic             out_q, out_d;
    logic             wr;
`ifdef MULTI_BLINKER_ONESHOT_EN
    logic             busy_q, busy_d;
`endif

    // Channels >= CHANNELS never match, so such writes complete but are dropped
    assign wr = accept && (cfg.cfg_chan == 4'(c));

    always_comb begin
      period_d = period_q;
      duty_d   = duty_q;
      offset_d = offset_q;
      ph_d     = ph_q;
      mode_d   = mode_q;
`ifdef MULTI_BLINKER_ONESHOT_EN
      busy_d   = busy_q;
`endif
      if (wr) begin
        // A field write wins over a coincident tick advance on this channel
        unique case (cfg.cfg_sel)
          SEL_PERIOD: begin
            period_d = cfg.cfg_data;
            // Re-align to the stored offset so ph always stays inside the new period
            ph_d     = (offset_q < cfg.cfg_data) ? offset_q : '0;
          end
          SEL_DUTY: begin
            duty_d = cfg.cfg_data;
          end
          SEL_OFFSET: begin
            offset_d = cfg.cfg_data;
            ph_d     = (cfg.cfg_data < period_q) ? cfg.cfg_data : '0;
          end
          SEL_MODE: begin
            mode_d = cfg.cfg_data[1:0];
            ph_d   = '0;
`ifdef MULTI_BLINKER_ONESHOT_EN
            busy_d = (cfg.cfg_data[1:0] == MODE_ONESHOT);
`endif
          end
          default: begin
            period_d = period_q;
          end
        endcase
      end else if (tick_q) begin
        if (period_q == '0) begin
          ph_d = '0;
        end else if (ph_q == period_q - WIDTH'(1)) begin
          ph_d = '0;
`ifdef MULTI_BLINKER_ONESHOT_EN
          if (mode_q == MODE_ONESHOT) begin
            mode_d = MODE_OFF;
            busy_d = 1'b0;
          end
`endif
        end else begin
          ph_d = ph_q + WIDTH'(1);
        end
      end
    end

    always_comb begin
      out_d = 1'b0;
      unique case (mode_q)
        MODE_OFF:     out_d = 1'b0;
        MODE_ON:      out_d = 1'b1;
        MODE_BLINK:   out_d = (period_q != '0) && (ph_q < duty_q);
`ifdef MULTI_BLINKER_ONESHOT_EN
        MODE_ONESHOT: out_d = (period_q != '0) && (ph_q < duty_q);
`else
        MODE_ONESHOT: out_d = 1'b0;
`endif
        default:      out_d = 1'b0;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        period_q <= '0;
        duty_q   <= '0;
        offset_q <= '0;
        ph_q     <= '0;
        mode_q   <= MODE_OFF;
        out_q    <= 1'b0;
      end else begin
        period_q <= period_d;
        duty_q   <= duty_d;
        offset_q <= offset_d;
        ph_q     <= ph_d;
        mode_q   <= mode_d;
        out_q    <= out_d;
      end
    end

`ifdef MULTI_BLINKER_ONESHOT_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        busy_q <= 1'b0;
      end else begin
        busy_q <= busy_d;
      end
    end

    assign busy[c] = busy_q;
`else
    assign busy[c] = 1'b0;
`endif

    assign blink_out[c] = out_q;
  end

endmodule

// File: tb/tb_multi_blinker.sv
// Self-checking bench for multi_blinker: directed scenarios plus randomized channel
// programming checked against an arithmetic phase model.
module tb_multi_blinker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick, tick4;
  logic [3:0] blink_out, blink_out4;
  logic [3:0] busy, busy4;

  int checks = 0;
  int errors = 0;

`ifdef MULTI_BLINKER_ONESHOT_EN
  localparam bit OS = 1'b1;
`else
  localparam bit OS = 1'b0;
`endif

  multi_blinker_if #(.WIDTH(16)) bus ();
  multi_blinker_if #(.WIDTH(16)) bus4 ();

  multi_blinker #(.CHANNELS(4), .WIDTH(16), .PRESCALE(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (bus),
    .tick      (tick),
    .blink_out (blink_out),
    .busy      (busy)
  );

  multi_blinker #(.CHANNELS(4), .WIDTH(16), .PRESCALE(4)) u_dut_p4 (
    .clk       (clk),
    .rst       (rst),
    .cfg       (bus4),
    .tick      (tick4),
    .blink_out (blink_out4),
    .busy      (busy4)
  );

  always #5 clk = ~clk;

  // Expected output k cycles after the aligning write (ph0 = phase right after it).
  function automatic logic ref_out(input int mode, input int p, input int duty,
                                   input int ph0, input int k);
    if (k < 1) return 1'b0;
    if (mode == 1) return 1'b1;
    if (mode == 0 || p == 0) return 1'b0;
    if (mode == 3) begin
      if (!OS || (k - 1) >= p) return 1'b0;
      return ((k - 1) < duty);
    end
    return (((ph0 + k - 1) % p) < duty);
  endfunction

  function automatic logic ref_busy(input int mode, input int p, input int k);
    if (mode != 3 || !OS) return 1'b0;
    return (k < p);
  endfunction

  task automatic cfg_write(input logic [3:0] ch, input logic [1:0] sel, input logic [15:0] data);
    int n = 0;
    @(negedge clk);
    while (!bus.cfg_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_write_ready got=%b exp=1", bus.cfg_ready);
    end
    bus.cfg_valid = 1'b1;
    bus.cfg_chan  = ch;
    bus.cfg_sel   = sel;
    bus.cfg_data  = data;
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cfg_ready, tick, tick4, blink_out, busy, blink_out4, busy4} !== '0) begin
      errors++;
      $display("FAIL reset_state got ready=%b tick=%b/%b out=%b busy=%b exp all 0",
               bus.cfg_ready, tick, tick4, blink_out, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cfg_ready !== 1'b1 || bus4.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b/%b exp=1/1", bus.cfg_ready, bus4.cfg_ready);
    end
  endtask

  task automatic test_tick();
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tick4 !== ((k % 4) == 3)) begin
        errors++;
        $display("FAIL tick_p4 edge=%0d got=%b exp=%b", k, tick4, ((k % 4) == 3));
      end
      checks++;
      if (tick !== 1'b1) begin
        errors++;
        $display("FAIL tick_p1 edge=%0d got=%b exp=1", k, tick);
      end
    end
  endtask

  task automatic test_blink();
    cfg_write(4'd0, 2'd0, 16'd4);
    cfg_write(4'd0, 2'd1, 16'd1);
    cfg_write(4'd0, 2'd3, 16'd2);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (blink_out[0] !== ref_out(2, 4, 1, 0, k)) begin
        errors++;
        $display("FAIL blink_ch0 k=%0d got=%b exp=%b", k, blink_out[0], ref_out(2, 4, 1, 0, k));
      end
    end
  endtask

  task automatic test_offset();
    cfg_write(4'd1, 2'd0, 16'd8);
    cfg_write(4'd1, 2'd1, 16'd4);
    cfg_write(4'd1, 2'd3, 16'd2);
    cfg_write(4'd1, 2'd2, 16'd6);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (blink_out[1] !== ref_out(2, 8, 4, 6, k)) begin
        errors++;
        $display("FAIL offset_ch1 k=%0d got=%b exp=%b", k, blink_out[1], ref_out(2, 8, 4, 6, k));
      end
    end
  endtask

  task automatic test_back_to_back();
    cfg_write(4'd3, 2'd0, 16'd4);
    cfg_write(4'd3, 2'd1, 16'd4);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pre_ready got=%b exp=1", bus.cfg_ready);
    end
    bus.cfg_valid = 1'b1;
    bus.cfg_chan  = 4'd3;
    bus.cfg_sel   = 2'd3;
    bus.cfg_data  = 16'd0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_after_first got=%b exp=0", bus.cfg_ready);
    end
    @(negedge clk);
    bus.cfg_data = 16'd1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cfg_ready !== 1'b1 || blink_out[3] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_edge got ready=%b out=%b exp ready=1 out=0",
               bus.cfg_ready, blink_out[3]);
    end
    @(negedge clk);
    bus.cfg_data = 16'd2;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cfg_ready !== 1'b0 || blink_out[3] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_third_edge got ready=%b out=%b exp ready=0 out=0",
               bus.cfg_ready, blink_out[3]);
    end
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (blink_out[3] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accepted got out=%b exp=1", blink_out[3]);
    end
  endtask

  task automatic test_oneshot();
    cfg_write(4'd2, 2'd0, 16'd5);
    cfg_write(4'd2, 2'd1, 16'd3);
    cfg_write(4'd2, 2'd3, 16'd3);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (busy[2] !== ref_busy(3, 5, k) || (k > 0 && blink_out[2] !== ref_out(3, 5, 3, 0, k)))
      begin
        errors++;
        $display("FAIL oneshot_ch2 k=%0d got out=%b busy=%b exp out=%b busy=%b", k,
                 blink_out[2], busy[2], ref_out(3, 5, 3, 0, k), ref_busy(3, 5, k));
      end
    end
    // Restart, then abort with a mode rewrite
    cfg_write(4'd2, 2'd3, 16'd3);
    checks++;
    if (busy[2] !== OS) begin
      errors++;
      $display("FAIL oneshot_restart got busy=%b exp=%b", busy[2], OS);
    end
    @(posedge clk);
    cfg_write(4'd2, 2'd3, 16'd0);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (busy[2] !== 1'b0 || (k > 0 && blink_out[2] !== 1'b0)) begin
        errors++;
        $display("FAIL oneshot_abort k=%0d got out=%b busy=%b exp 0/0", k, blink_out[2], busy[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    cfg_write(4'd0, 2'd0, 16'd0);
    cfg_write(4'd0, 2'd3, 16'd1);
    cfg_write(4'd2, 2'd0, 16'd15);
    cfg_write(4'd2, 2'd1, 16'd15);
    cfg_write(4'd2, 2'd3, 16'd3);
    @(posedge clk);
    #1;
    checks++;
    if (blink_out[0] !== 1'b1 || busy[2] !== OS) begin
      errors++;
      $display("FAIL rstmid_pre got out0=%b busy2=%b exp 1/%b", blink_out[0], busy[2], OS);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({blink_out, tick, tick4, busy, bus.cfg_ready} !== '0) begin
      errors++;
      $display("FAIL rstmid_async got out=%b tick=%b busy=%b ready=%b exp all 0",
               blink_out, tick, busy, bus.cfg_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.cfg_ready !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_held got ready=%b tick=%b exp 0/0", bus.cfg_ready, tick);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_release got ready=%b exp=1", bus.cfg_ready);
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (blink_out !== 4'b0000 || busy !== 4'b0000) begin
        errors++;
        $display("FAIL rstmid_cleared k=%0d got out=%b busy=%b exp 0/0", k, blink_out, busy);
      end
    end
  endtask

  task automatic test_discard();
    cfg_write(4'd9, 2'd3, 16'd1);
    checks++;
    if (bus.cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL discard_handshake got ready=%b exp=0", bus.cfg_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (blink_out !== 4'b0000) begin
        errors++;
        $display("FAIL discard_no_effect k=%0d got out=%b exp=0000", k, blink_out);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int ch, mode, p, duty, off, ph0, n;
      ch   = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 3));
      p    = int'($urandom_range(0, 12));
      duty = int'($urandom_range(0, 14));
      off  = int'($urandom_range(0, 15));
      if (mode == 3 && p == 0) p = 1;
      cfg_write(4'(ch), 2'd0, 16'(p));
      cfg_write(4'(ch), 2'd1, 16'(duty));
      cfg_write(4'(ch), 2'd3, 16'(mode));
      ph0 = 0;
      if (mode != 3) begin
        cfg_write(4'(ch), 2'd2, 16'(off));
        ph0 = (off < p) ? off : 0;
      end
      n = 2 * ((p > 0) ? p : 1) + 3;
      for (int k = 0; k <= n; k++) begin
        if (k > 0) begin
          @(posedge clk);
          #1;
        end
        checks++;
        if (busy[ch] !== ref_busy(mode, p, k) ||
            (k > 0 && blink_out[ch] !== ref_out(mode, p, duty, ph0, k))) begin
          errors++;
          $display("FAIL random t=%0d ch=%0d mode=%0d p=%0d d=%0d ph0=%0d k=%0d got out=%b busy=%b exp out=%b busy=%b",
                   t, ch, mode, p, duty, ph0, k, blink_out[ch], busy[ch],
                   ref_out(mode, p, duty, ph0, k), ref_busy(mode, p, k));
        end
      end
    end
  endtask

  initial begin
    bus.cfg_valid  = 1'b0;
    bus.cfg_chan   = '0;
    bus.cfg_sel    = '0;
    bus.cfg_data   = '0;
    bus4.cfg_valid = 1'b0;
    bus4.cfg_chan  = '0;
    bus4.cfg_sel   = '0;
    bus4.cfg_data  = '0;
    test_reset();
    test_tick();
    test_blink();
    test_offset();
    test_back_to_back();
    test_oneshot();
    test_reset_mid();
    test_discard();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
